// File: rtl/fp32_sub_seq.sv
// =============================================================================
// Module      : fp32_sub_seq
// Description : Multi-cycle FP32 subtractor (a - b), fixed 5-cycle latency, RNE, DAZ/FTZ.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module fp32_sub_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADDSUB = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5
    } state_t;

    state_t r_state, w_next;

    logic [31:0] r_a, r_b;
    logic        r_sx, r_sy, r_spec;
    logic [7:0]  r_ex, r_ey;
    logic [26:0] r_mx, r_my;
    logic [31:0] r_spec_val;
    logic        r_sl, r_ss;
    logic [7:0]  r_el;
    logic [26:0] r_ml, r_ms;
    logic [27:0] r_sum;
    logic [7:0]  r_se;
    logic        r_ssign;
    logic [26:0] r_nm;
    logic [9:0]  r_ne;
    logic        r_nsign, r_nzero;
    logic [31:0] r_result;
    logic        r_ovf, r_unf;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_UNPACK;
            S_UNPACK: w_next = S_ALIGN;
            S_ALIGN:  w_next = S_ADDSUB;
            S_ADDSUB: w_next = S_NORM;
            S_NORM:   w_next = S_ROUND;
            S_ROUND:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- UNPACK ----------------
    logic        w_sa, w_sb, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_fa, w_fb;
    logic        w_spec;
    logic [31:0] w_spec_val;

    assign w_sa     = r_a[31];
    assign w_sb     = ~r_b[31];
    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_fa     = r_a[22:0];
    assign w_fb     = r_b[22:0];
    assign w_a_zero = (w_ea == 8'd0);
    assign w_b_zero = (w_eb == 8'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);

    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = C_QNAN;
        if (w_a_nan || w_b_nan)
            w_spec_val = C_QNAN;
        else if (w_a_inf && w_b_inf)
            w_spec_val = (w_sa == w_sb) ? {w_sa, 8'hFF, 23'd0} : C_QNAN;
        else if (w_a_inf)
            w_spec_val = {w_sa, 8'hFF, 23'd0};
        else if (w_b_inf)
            w_spec_val = {w_sb, 8'hFF, 23'd0};
        else if (w_a_zero && w_b_zero)
            // Signed-zero sum: only (-0) + (-0) keeps the minus sign.
            w_spec_val = {w_sa & w_sb, 31'd0};
        else
            w_spec = 1'b0;
    end

    // ---------------- ALIGN ----------------
    logic        w_x_ge, w_sl, w_ss;
    logic [7:0]  w_el, w_es, w_d;
    logic [26:0] w_ml, w_ms_raw, w_msh, w_mask;

    assign w_x_ge   = {r_ex, r_mx} >= {r_ey, r_my};
    assign w_sl     = w_x_ge ? r_sx : r_sy;
    assign w_ss     = w_x_ge ? r_sy : r_sx;
    assign w_el     = w_x_ge ? r_ex : r_ey;
    assign w_es     = w_x_ge ? r_ey : r_ex;
    assign w_ml     = w_x_ge ? r_mx : r_my;
    assign w_ms_raw = w_x_ge ? r_my : r_mx;
    assign w_d      = w_el - w_es;

    always_comb begin
        w_mask = 27'd0;
        if (w_d >= 8'd27) begin
            w_msh = {26'd0, |w_ms_raw};
        end else begin
            w_msh    = w_ms_raw >> w_d;
            w_mask   = (27'd1 << w_d) - 27'd1;
            w_msh[0] = w_msh[0] | (|(w_ms_raw & w_mask));
        end
    end

    // ---------------- NORM ----------------
    logic [4:0]  w_lzc;
    logic        w_found;
    logic [26:0] w_nm;
    logic [9:0]  w_ne;

    always_comb begin
        w_lzc   = 5'd0;
        w_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!w_found) begin
                if (r_sum[i]) w_found = 1'b1;
                else          w_lzc   = w_lzc + 5'd1;
            end
        end
    end

    always_comb begin
        if (r_sum[27]) begin
            w_nm = {r_sum[27:2], r_sum[1] | r_sum[0]};
            w_ne = {2'b00, r_se} + 10'd1;
        end else begin
            w_nm = r_sum[26:0] << w_lzc;
            w_ne = {2'b00, r_se} - {5'd0, w_lzc};
        end
    end

    // ---------------- ROUND ----------------
    logic        w_rup, w_ovf, w_unf;
    logic [24:0] w_mant25;
    logic [9:0]  w_re;
    logic [22:0] w_frac;
    logic [31:0] w_res;

    assign w_rup    = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
    assign w_mant25 = {1'b0, r_nm[26:3]} + {24'd0, w_rup};
    assign w_re     = r_ne + (w_mant25[24] ? 10'd1 : 10'd0);
    assign w_frac   = w_mant25[24] ? w_mant25[23:1] : w_mant25[22:0];

    always_comb begin
        w_res = {r_nsign, w_re[7:0], w_frac};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        if (r_spec) begin
            w_res = r_spec_val;
        end else if (r_nzero) begin
            w_res = 32'd0;
        end else if (!w_re[9] && (w_re >= 10'd255)) begin
            w_res = {r_nsign, 8'hFF, 23'd0};
            w_ovf = 1'b1;
        end else if (w_re[9] || (w_re == 10'd0)) begin
            w_res = {r_nsign, 31'd0};
            w_unf = 1'b1;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= 32'd0;  r_b <= 32'd0;
            r_sx <= 1'b0;  r_sy <= 1'b0;  r_ex <= 8'd0;  r_ey <= 8'd0;
            r_mx <= 27'd0; r_my <= 27'd0; r_spec <= 1'b0; r_spec_val <= 32'd0;
            r_sl <= 1'b0;  r_ss <= 1'b0;  r_el <= 8'd0;  r_ml <= 27'd0; r_ms <= 27'd0;
            r_sum <= 28'd0; r_se <= 8'd0; r_ssign <= 1'b0;
            r_nm <= 27'd0; r_ne <= 10'd0; r_nsign <= 1'b0; r_nzero <= 1'b0;
            r_result <= 32'd0; r_ovf <= 1'b0; r_unf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_a <= a;
                    r_b <= b;
                end
                S_UNPACK: begin
                    r_sx       <= w_sa;
                    r_sy       <= w_sb;
                    r_ex       <= w_ea;
                    r_ey       <= w_eb;
                    r_mx       <= w_a_zero ? 27'd0 : {1'b1, w_fa, 3'b000};
                    r_my       <= w_b_zero ? 27'd0 : {1'b1, w_fb, 3'b000};
                    r_spec     <= w_spec;
                    r_spec_val <= w_spec_val;
                end
                S_ALIGN: begin
                    r_sl <= w_sl;
                    r_ss <= w_ss;
                    r_el <= w_el;
                    r_ml <= w_ml;
                    r_ms <= w_msh;
                end
                S_ADDSUB: begin
                    r_sum   <= (r_sl == r_ss) ? ({1'b0, r_ml} + {1'b0, r_ms})
                                              : ({1'b0, r_ml} - {1'b0, r_ms});
                    r_se    <= r_el;
                    r_ssign <= r_sl;
                end
                S_NORM: begin
                    r_nm    <= w_nm;
                    r_ne    <= w_ne;
                    r_nsign <= r_ssign;
                    r_nzero <= (r_sum == 28'd0);
                end
                S_ROUND: begin
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                    r_unf    <= w_unf;
                end
                default: ;
            endcase
        end
    end

    // Result is presented live in the ROUND cycle and held afterwards.
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_ROUND);
        result    = done ? w_res : r_result;
        overflow  = done ? w_ovf : r_ovf;
        underflow = done ? w_unf : r_unf;
    end

endmodule

`default_nettype wire

// File: tb/tb_fp32_sub_seq.sv
// =============================================================================
// Module      : tb_fp32_sub_seq
// Description : Directed self-checking bench for fp32_sub_seq.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_fp32_sub_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, overflow, underflow;
    logic [31:0] result;

    int vectors;
    int miscompares;

    fp32_sub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and waits (bounded) for done; performs no checking.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output logic [31:0] r, output logic o, output logic u,
                          output int lat);
        r = 32'd0; o = 1'b0; u = 1'b0; lat = 0;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k; r = result; o = overflow; u = underflow;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, overflow, underflow, result} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b ovf=%b unf=%b result=%h, want all 0",
                     busy, done, overflow, underflow, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith;
        logic [97:0] tab [10] = '{
            {32'h42C80000, 32'h3E800000, 32'h42C78000, 2'b00},  // 100 - 0.25
            {32'h3F800000, 32'hBF800000, 32'h40000000, 2'b00},  // 1 - (-1)
            {32'h40400000, 32'h40400000, 32'h00000000, 2'b00},  // x - x
            {32'h3F800000, 32'h33000000, 32'h3F800000, 2'b00},  // RNE tie to even
            {32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 2'b00},  // exact 1 - 2^-24
            {32'h3F800000, 32'h40000000, 32'hBF800000, 2'b00},  // 1 - 2
            {32'h40400000, 32'h3F800000, 32'h40000000, 2'b00},  // 3 - 1
            {32'h00000001, 32'h3F800000, 32'hBF800000, 2'b00},  // denormal as zero
            {32'h00000000, 32'h00000000, 32'h00000000, 2'b00},  // (+0)-(+0)
            {32'h80000000, 32'h00000000, 32'h80000000, 2'b00}   // (-0)-(+0)
        };
        logic [31:0] r;
        logic o, u;
        int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(tab[i][97:66], tab[i][65:34], r, o, u, lat);
            vectors++;
            if ({r, o, u} !== tab[i][33:0] || lat != 5) begin
                miscompares++;
                $display("FAIL arith[%0d] %h-%h: got %h ovf=%b unf=%b lat=%0d, want %h ovf=%b unf=%b lat=5",
                         i, tab[i][97:66], tab[i][65:34], r, o, u, lat,
                         tab[i][33:2], tab[i][1], tab[i][0]);
            end
        end
    endtask

    task automatic test_specials;
        logic [97:0] tab [7] = '{
            {32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 2'b10},  // overflow to +inf
            {32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000, 2'b10},  // overflow to -inf
            {32'h7F800000, 32'h7F800000, 32'h7FC00000, 2'b00},  // inf - inf
            {32'h7F800000, 32'hFF800000, 32'h7F800000, 2'b00},  // inf - (-inf)
            {32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2'b00},  // NaN in
            {32'h3F800000, 32'h7F800000, 32'hFF800000, 2'b00},  // finite - inf
            {32'h00800001, 32'h00800000, 32'h00000000, 2'b01}   // flush to zero
        };
        logic [31:0] r;
        logic o, u;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(tab[i][97:66], tab[i][65:34], r, o, u, lat);
            vectors++;
            if ({r, o, u} !== tab[i][33:0] || lat != 5) begin
                miscompares++;
                $display("FAIL special[%0d] %h-%h: got %h ovf=%b unf=%b lat=%0d, want %h ovf=%b unf=%b lat=5",
                         i, tab[i][97:66], tab[i][65:34], r, o, u, lat,
                         tab[i][33:2], tab[i][1], tab[i][0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int d_cnt;
        int d_cyc [2];
        logic [31:0] d_res [2];
        d_cnt = 0; d_cyc[0] = 0; d_cyc[1] = 0; d_res[0] = 32'd0; d_res[1] = 32'd0;
        @(negedge clk);
        start = 1'b1; a = 32'h42C80000; b = 32'h3E800000;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                if (d_cnt < 2) begin
                    d_cyc[d_cnt] = c;
                    d_res[d_cnt] = result;
                end
                d_cnt++;
            end
            if (c == 6) begin
                a = 32'h40400000; b = 32'h3F800000;
            end else begin
                a = 32'h7F800000 ^ c; b = 32'hC1200000 + c;
            end
            if (c == 12) start = 1'b0;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) d_cnt++;
        end
        vectors++;
        if (d_cnt != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d done cycles, want 2", d_cnt);
        end
        vectors++;
        if (d_cyc[0] != 5 || d_cyc[1] != 11) begin
            miscompares++;
            $display("FAIL b2b_timing: got done at cycles %0d,%0d, want 5,11", d_cyc[0], d_cyc[1]);
        end
        vectors++;
        if (d_res[0] !== 32'h42C78000 || d_res[1] !== 32'h40000000) begin
            miscompares++;
            $display("FAIL b2b_results: got %h,%h, want 42c78000,40000000", d_res[0], d_res[1]);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] r;
        logic o, u, seen;
        int lat;
        @(negedge clk);
        start = 1'b1; a = 32'h3F800000; b = 32'hBF800000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, result} !== 34'd0) begin
            miscompares++;
            $display("FAIL abort_async: got busy=%b done=%b result=%h, want 0 0 00000000",
                     busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: got activity=%b after reset, want 0", seen);
        end
        run_op(32'h42C80000, 32'h3E800000, r, o, u, lat);
        vectors++;
        if (r !== 32'h42C78000 || lat != 5) begin
            miscompares++;
            $display("FAIL abort_recover: got %h lat=%0d, want 42c78000 lat=5", r, lat);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_arith;
        test_specials;
        test_back_to_back;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
